fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: variable-latency imem handshake feeding the IF/ID register.
// Define FETCH_STATS_EN to add the fetch_count/stall_count statistics outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [2:0]  pc_write,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_addr_q;
  logic [31:0] hold_instr_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;

  logic        pc_write_en;
  logic        load_mem;
  logic        load_hold;
  logic        clr_valid;
  logic        latch_addr;
  logic        capture_hold;
  logic        req_active;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush outranks both stall and imem_ack
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (flush && !imem_ack)      state_d = DRAIN;
        else if (!flush && imem_ack && stall) state_d = HOLD;
        else                          state_d = REQ;
      end
      HOLD:  if (flush || !stall) state_d = REQ;
      DRAIN: if (imem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    pc_write_en  = 1'b0;
    req_active   = 1'b0;
    load_mem     = 1'b0;
    load_hold    = 1'b0;
    clr_valid    = 1'b0;
    latch_addr   = 1'b0;
    capture_hold = 1'b0;
    unique case (state_q)
      IDLE: latch_addr = 1'b1;
      REQ: begin
        req_active = 1'b1;
        if (flush) begin
          pc_write_en = 1'b1;
          clr_valid   = 1'b1;
          latch_addr  = imem_ack;
        end else if (imem_ack) begin
          if (!stall) begin
            load_mem    = 1'b1;
            pc_write_en = 1'b1;
            latch_addr  = 1'b1;
          end else begin
            capture_hold = 1'b1;
          end
        end else if (!stall) begin
          clr_valid = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_write_en = 1'b1;
          clr_valid   = 1'b1;
          latch_addr  = 1'b1;
        end else if (!stall) begin
          load_hold   = 1'b1;
          pc_write_en = 1'b1;
          latch_addr  = 1'b1;
        end
      end
      DRAIN: begin
        // The stale response is still owed; keep requesting the old address.
        req_active = 1'b1;
        if (flush) begin
          pc_write_en = 1'b1;
          clr_valid   = 1'b1;
        end
        latch_addr = imem_ack;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write_en = 1'b0;
      req_active  = 1'b0;
    end
  end

  assign pc_write  = {3{pc_write_en}};
  assign imem_req  = req_active;
  assign imem_addr = req_addr_q;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_q   <= RESET_PC;
      hold_instr_q <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= RESET_PC;
      ifid_pc4_q   <= RESET_PC + 32'd4;
    end else begin
      if (latch_addr)   req_addr_q   <= pc;
      if (capture_hold) hold_instr_q <= imem_rdata;
      if (load_mem) begin
        ifid_valid_q <= 1'b1;
        ifid_instr_q <= imem_rdata;
        ifid_pc_q    <= req_addr_q;
        ifid_pc4_q   <= req_addr_q + 32'd4;
      end else if (load_hold) begin
        ifid_valid_q <= 1'b1;
        ifid_instr_q <= hold_instr_q;
        ifid_pc_q    <= req_addr_q;
        ifid_pc4_q   <= req_addr_q + 32'd4;
      end else if (clr_valid) begin
        ifid_valid_q <= 1'b0;
      end
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (load_mem || load_hold)   fetch_count_q <= fetch_count_q + 32'd1;
      if (stall && ifid_valid_q)   stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait, wait-state, stall/HOLD, flush/DRAIN, reset and wrap cases.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [2:0]  pc_write;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] target;
  int n_checks = 0;
  int n_fails  = 0;

  fetch_unit #(.RESET_PC(32'h00003000)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pc_write   (pc_write),
    .pc_plus4   (pc_plus4),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_pc4   (ifid_pc4)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      $display("check %-16s observed %h", tag, obs);
    end else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the PC model updates on the negedge when pc_write allows it.
  task automatic step();
    @(negedge clk);
    if (pc_write === 3'b111) pc = flush ? target : pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = 32'h00003000; imem_ack = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; flush = 1'b0; target = 32'd0;
    step();
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_instr", ifid_instr, 32'd0);
    check("rst_pc",    ifid_pc,    32'h00003000);
    check("rst_pc4",   ifid_pc4,   32'h00003004);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_pcw",   32'(pc_write), 32'd0);

    reset = 1'b0; #1;
    check("idle_pcw", 32'(pc_write), 32'd0);
    check("idle_req", 32'(imem_req), 32'd0);
    step();

    // zero-wait memory
    imem_ack = 1'b1; imem_rdata = 32'h20080005; #1;
    check("zw_req",  32'(imem_req), 32'd1);
    check("zw_addr", imem_addr, 32'h00003000);
    check("zw_pcw",  32'(pc_write), 32'h7);
    step();
    check("zw_valid", 32'(ifid_valid), 32'd1);
    check("zw_instr", ifid_instr, 32'h20080005);
    check("zw_pc",    ifid_pc,    32'h00003000);
    check("zw_pc4",   ifid_pc4,   32'h00003004);
    imem_rdata = 32'h11111111; #1;
    check("zw2_addr", imem_addr, 32'h00003004);
    check("zw2_pcw",  32'(pc_write), 32'h7);
    step();
    check("zw2_pc",    ifid_pc,    32'h00003004);
    check("zw2_instr", ifid_instr, 32'h11111111);

    // three wait states before the ack
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_addr", imem_addr, 32'h00003008);
      check("ws_pcw",  32'(pc_write), 32'd0);
      check("ws_req",  32'(imem_req), 32'd1);
      step();
      check("ws_bubble", 32'(ifid_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h22222222; #1;
    check("ws_ack_pcw", 32'(pc_write), 32'h7);
    step();
    check("ws_valid", 32'(ifid_valid), 32'd1);
    check("ws_pc",    ifid_pc,    32'h00003008);
    check("ws_instr", ifid_instr, 32'h22222222);

    // ack during a two-cycle stall
    stall = 1'b1; imem_rdata = 32'h33333333; #1;
    check("st_pcw", 32'(pc_write), 32'd0);
    step();
    check("st_frz_valid", 32'(ifid_valid), 32'd1);
    check("st_frz_pc",    ifid_pc,    32'h00003008);
    check("st_frz_instr", ifid_instr, 32'h22222222);
    imem_ack = 1'b0; imem_rdata = 32'd0; #1;
    check("hold_req", 32'(imem_req), 32'd0);
    check("hold_pcw", 32'(pc_write), 32'd0);
    step();
    check("hold_frz_instr", ifid_instr, 32'h22222222);
    stall = 1'b0; #1;
    check("hold_rel_pcw", 32'(pc_write), 32'h7);
    check("hold_rel_req", 32'(imem_req), 32'd0);
    step();
    check("hold_valid", 32'(ifid_valid), 32'd1);
    check("hold_instr", ifid_instr, 32'h33333333);
    check("hold_pc",    ifid_pc,    32'h0000300C);
    check("hold_pc4",   ifid_pc4,   32'h00003010);
`ifdef FETCH_STATS_EN
    check("stat_fetch", fetch_count, 32'd4);
    check("stat_stall", stall_count, 32'd2);
`endif

    // flush with the request outstanding
    flush = 1'b1; target = 32'h00003040; #1;
    check("fl_pcw",  32'(pc_write), 32'h7);
    check("fl_addr", imem_addr, 32'h00003010);
    step();
    check("fl_valid", 32'(ifid_valid), 32'd0);
    flush = 1'b0; #1;
    check("dr_req",  32'(imem_req), 32'd1);
    check("dr_addr", imem_addr, 32'h00003010);
    check("dr_pcw",  32'(pc_write), 32'd0);
    step();
    check("dr_valid", 32'(ifid_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; #1;
    check("dr_ack_pcw", 32'(pc_write), 32'd0);
    step();
    check("dr_valid2", 32'(ifid_valid), 32'd0);
    check("dr_discard", ifid_instr, 32'h33333333);
    imem_ack = 1'b0; #1;
    check("re_addr", imem_addr, 32'h00003040);
    check("re_req",  32'(imem_req), 32'd1);
    step();
    check("re_valid", 32'(ifid_valid), 32'd0);

    // flush coinciding with an ack
    imem_ack = 1'b1; imem_rdata = 32'h55555555; flush = 1'b1; target = 32'h00003100; #1;
    check("fa_pcw", 32'(pc_write), 32'h7);
    step();
    check("fa_valid", 32'(ifid_valid), 32'd0);
    flush = 1'b0; imem_ack = 1'b0; #1;
    check("fa_addr", imem_addr, 32'h00003100);

    // reset while in DRAIN
    flush = 1'b1; target = 32'h00003080;
    step();
    flush = 1'b0; reset = 1'b1; #1;
    check("rd_req", 32'(imem_req), 32'd0);
    check("rd_pcw", 32'(pc_write), 32'd0);
    step();
    check("rd_valid", 32'(ifid_valid), 32'd0);
    check("rd_instr", ifid_instr, 32'd0);
    check("rd_pc",    ifid_pc,    32'h00003000);
    check("rd_pc4",   ifid_pc4,   32'h00003004);
`ifdef FETCH_STATS_EN
    check("rd_fetch", fetch_count, 32'd0);
`endif

    // address wrap at the top of memory
    reset = 1'b0; pc = 32'hFFFFFFFC; #1;
    check("wr_idle_req", 32'(imem_req), 32'd0);
    check("wr_plus4",    pc_plus4, 32'd0);
    step();
    imem_ack = 1'b1; imem_rdata = 32'h44444444; #1;
    check("wr_addr", imem_addr, 32'hFFFFFFFC);
    step();
    check("wr_pc",    ifid_pc,    32'hFFFFFFFC);
    check("wr_pc4",   ifid_pc4,   32'd0);
    check("wr_instr", ifid_instr, 32'h44444444);
    imem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
